// File: rtl/uart_rx_datapath.sv
// UART receive datapath: synchronises the serial line, times the FSM wait states
// and assembles the received byte with parity and stop-bit checks.
module uart_rx_datapath #(
  parameter int CLKS_PER_BIT = 434,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_in,
  input  logic       datastate,
  input  logic       parity,
  input  logic       stop,
  input  logic       waitstate,
  output logic       frame,
  output logic       maxflag,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(2 * CLKS_PER_BIT);
  // Terminal counts are W-1; the first wait is shortened by the FSM's fixed start-up cycles.
  localparam logic [CNT_W-1:0] TERM_FIRST = CNT_W'(CLKS_PER_BIT + CLKS_PER_BIT / 2 - 6);
  localparam logic [CNT_W-1:0] TERM_NEXT  = CNT_W'(CLKS_PER_BIT - 2);

  logic             sync_p0;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] term;
  logic [3:0]       bits_rcvd;
  logic [7:0]       shreg;
  logic             par_err;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= 4'd8) ? 4'd8 : v + 4'd1;
  endfunction

  function automatic logic parity_check(input logic [7:0] bits, input logic pbit);
    return (^bits) ^ pbit ^ PARITY_ODD;
  endfunction

  // Stage p0 -> frame: two-flop synchroniser, idles high
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0 <= 1'b1;
      frame   <= 1'b1;
    end else begin
      sync_p0 <= rx_in;
      frame   <= sync_p0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt <= '0;
    end else if (waitstate) begin
      bit_cnt <= bit_cnt + CNT_W'(1);
    end else begin
      bit_cnt <= '0;
    end
  end

  assign term    = (bits_rcvd == 4'd0) ? TERM_FIRST : TERM_NEXT;
  assign maxflag = waitstate && (bit_cnt == term);

  // Byte assembly: stop outranks parity, parity outranks data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bits_rcvd  <= '0;
      shreg      <= '0;
      par_err    <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (stop) begin
        rx_data    <= shreg;
        parity_err <= par_err;
        frame_err  <= ~frame;
        rx_valid   <= 1'b1;
        bits_rcvd  <= '0;
      end else if (parity) begin
        par_err <= parity_check(shreg, frame);
      end else if (datastate) begin
        shreg     <= {frame, shreg[7:1]};
        bits_rcvd <= sat_inc(bits_rcvd);
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_datapath.sv
// Directed bench: emulates the receive FSM's strobe timing against two datapaths
// (even and odd parity) sharing the same serial line and strobes.
module tb_uart_rx_datapath;

  logic       clk;
  logic       reset;
  logic       rx_in;
  logic       datastate;
  logic       parity;
  logic       stop;
  logic       waitstate;
  logic       frame_e, maxflag_e, rx_valid_e, parity_err_e, frame_err_e;
  logic       frame_o, maxflag_o, rx_valid_o, parity_err_o, frame_err_o;
  logic [7:0] rx_data_e, rx_data_o;

  int compared = 0;
  int failed   = 0;

  uart_rx_datapath #(.CLKS_PER_BIT(16), .PARITY_ODD(1'b0)) dut_e (
    .clk(clk), .reset(reset), .rx_in(rx_in), .datastate(datastate), .parity(parity),
    .stop(stop), .waitstate(waitstate), .frame(frame_e), .maxflag(maxflag_e),
    .rx_data(rx_data_e), .rx_valid(rx_valid_e), .parity_err(parity_err_e), .frame_err(frame_err_e)
  );

  uart_rx_datapath #(.CLKS_PER_BIT(16), .PARITY_ODD(1'b1)) dut_o (
    .clk(clk), .reset(reset), .rx_in(rx_in), .datastate(datastate), .parity(parity),
    .stop(stop), .waitstate(waitstate), .frame(frame_o), .maxflag(maxflag_o),
    .rx_data(rx_data_o), .rx_valid(rx_valid_o), .parity_err(parity_err_o), .frame_err(frame_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Serial line driver: start bit, 8 data bits LSB first, parity, stop; 16 clk per bit.
  task automatic drive_frame(input logic [7:0] data, input logic par, input logic stp, input int nbits);
    logic [10:0] bits;
    bits = {stp, par, data, 1'b0};
    @(posedge clk); #1;
    for (int i = 0; i <= nbits; i++) begin
      rx_in = bits[i];
      repeat (16) @(posedge clk);
      #1;
    end
    rx_in = 1'b1;
  endtask

  // Receive-FSM stand-in: IDLE sample, four fixed cycles, then wait/strobe per bit.
  task automatic fsm_frame(input int nstrobes, input bit use_odd, output bit tmo,
                           output logic v0, output logic v1, output logic v2,
                           output logic [7:0] d, output logic pe, output logic fe);
    int n;
    tmo = 1'b0; v0 = 1'b0; v1 = 1'b0; v2 = 1'b0; d = '0; pe = 1'b0; fe = 1'b0;
    n = 0;
    @(negedge clk);
    while (frame_e !== 1'b0 && n < 400) begin @(negedge clk); n++; end
    if (frame_e !== 1'b0) begin tmo = 1'b1; return; end
    repeat (5) @(posedge clk);
    #1;
    for (int b = 0; b < nstrobes; b++) begin
      waitstate = 1'b1;
      n = 0;
      @(negedge clk);
      while (maxflag_e !== 1'b1 && n < 64) begin @(negedge clk); n++; end
      if (maxflag_e !== 1'b1) begin tmo = 1'b1; waitstate = 1'b0; return; end
      @(posedge clk); #1;
      waitstate = 1'b0;
      datastate = (b < 8);
      parity    = (b == 8);
      stop      = (b == 9);
      if (b == 9) begin
        @(negedge clk);
        v0 = use_odd ? rx_valid_o : rx_valid_e;
      end
      @(posedge clk); #1;
      datastate = 1'b0; parity = 1'b0; stop = 1'b0;
      if (b == 9) begin
        @(negedge clk);
        v1 = use_odd ? rx_valid_o   : rx_valid_e;
        d  = use_odd ? rx_data_o    : rx_data_e;
        pe = use_odd ? parity_err_o : parity_err_e;
        fe = use_odd ? frame_err_o  : frame_err_e;
        @(negedge clk);
        v2 = use_odd ? rx_valid_o : rx_valid_e;
      end
    end
    if (nstrobes < 10) waitstate = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b0; rx_in = 1'b1; datastate = 1'b0; parity = 1'b0; stop = 1'b0; waitstate = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    compared++; if (rx_data_e !== 8'h00) begin failed++; $display("FAIL rst_data got=%h exp=00", rx_data_e); end
    compared++; if (rx_valid_e !== 1'b0) begin failed++; $display("FAIL rst_valid got=%b exp=0", rx_valid_e); end
    compared++; if ({parity_err_e, frame_err_e} !== 2'b00) begin failed++; $display("FAIL rst_errs got=%b exp=00", {parity_err_e, frame_err_e}); end
    compared++; if ({frame_e, frame_o} !== 2'b11) begin failed++; $display("FAIL rst_frame got=%b exp=11", {frame_e, frame_o}); end
    compared++; if ({maxflag_e, maxflag_o} !== 2'b00) begin failed++; $display("FAIL rst_maxflag got=%b exp=00", {maxflag_e, maxflag_o}); end
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_good_frame;
    bit tmo; logic v0, v1, v2, pe, fe; logic [7:0] d;
    fork
      drive_frame(8'hA5, 1'b0, 1'b1, 10);
      fsm_frame(10, 1'b0, tmo, v0, v1, v2, d, pe, fe);
    join
    compared++; if (tmo) begin failed++; $display("FAIL good_timeout got=timeout exp=strobes"); end
    compared++; if ({v0, v1, v2} !== 3'b010) begin failed++; $display("FAIL good_valid_pulse got=%b exp=010", {v0, v1, v2}); end
    compared++; if (d !== 8'hA5) begin failed++; $display("FAIL good_data got=%h exp=a5", d); end
    compared++; if ({pe, fe} !== 2'b00) begin failed++; $display("FAIL good_errs got=%b exp=00", {pe, fe}); end
  endtask

  task automatic test_parity_error;
    bit tmo; logic v0, v1, v2, pe, fe; logic [7:0] d;
    fork
      drive_frame(8'hA5, 1'b1, 1'b1, 10);
      fsm_frame(10, 1'b0, tmo, v0, v1, v2, d, pe, fe);
    join
    compared++; if (tmo) begin failed++; $display("FAIL perr_timeout got=timeout exp=strobes"); end
    compared++; if ({v0, v1, v2} !== 3'b010) begin failed++; $display("FAIL perr_valid_pulse got=%b exp=010", {v0, v1, v2}); end
    compared++; if (d !== 8'hA5) begin failed++; $display("FAIL perr_data got=%h exp=a5", d); end
    compared++; if ({pe, fe} !== 2'b10) begin failed++; $display("FAIL perr_errs got=%b exp=10", {pe, fe}); end
  endtask

  task automatic test_frame_error;
    bit tmo; logic v0, v1, v2, pe, fe; logic [7:0] d;
    fork
      drive_frame(8'h3C, 1'b0, 1'b0, 10);
      fsm_frame(10, 1'b0, tmo, v0, v1, v2, d, pe, fe);
    join
    compared++; if (tmo) begin failed++; $display("FAIL ferr_timeout got=timeout exp=strobes"); end
    compared++; if ({v0, v1, v2} !== 3'b010) begin failed++; $display("FAIL ferr_valid_pulse got=%b exp=010", {v0, v1, v2}); end
    compared++; if (d !== 8'h3C) begin failed++; $display("FAIL ferr_data got=%h exp=3c", d); end
    compared++; if ({pe, fe} !== 2'b01) begin failed++; $display("FAIL ferr_errs got=%b exp=01", {pe, fe}); end
    repeat (20) @(posedge clk);
    @(negedge clk);
    compared++; if ({rx_data_e, frame_err_e} !== {8'h3C, 1'b1}) begin failed++; $display("FAIL ferr_hold got=%h/%b exp=3c/1", rx_data_e, frame_err_e); end
  endtask

  task automatic test_reset_mid_frame;
    bit tmo; logic v0, v1, v2, pe, fe; logic [7:0] d;
    fork
      drive_frame(8'h00, 1'b0, 1'b1, 4);
      fsm_frame(4, 1'b0, tmo, v0, v1, v2, d, pe, fe);
    join
    compared++; if (tmo) begin failed++; $display("FAIL abort_timeout got=timeout exp=strobes"); end
    rx_in = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    compared++; if (rx_data_e !== 8'h00) begin failed++; $display("FAIL abort_rst_data got=%h exp=00", rx_data_e); end
    compared++; if ({rx_valid_e, parity_err_e, frame_err_e} !== 3'b000) begin failed++; $display("FAIL abort_rst_flags got=%b exp=000", {rx_valid_e, parity_err_e, frame_err_e}); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    compared++; if ({frame_e, maxflag_e} !== 2'b10) begin failed++; $display("FAIL abort_rst_frame_maxflag got=%b exp=10", {frame_e, maxflag_e}); end
    @(posedge clk); #1;
    waitstate = 1'b0; rx_in = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (20) @(posedge clk);
    fork
      drive_frame(8'h5A, 1'b0, 1'b1, 10);
      fsm_frame(10, 1'b0, tmo, v0, v1, v2, d, pe, fe);
    join
    compared++; if (tmo) begin failed++; $display("FAIL after_abort_timeout got=timeout exp=strobes"); end
    compared++; if ({v0, v1, v2} !== 3'b010) begin failed++; $display("FAIL after_abort_valid got=%b exp=010", {v0, v1, v2}); end
    compared++; if (d !== 8'h5A) begin failed++; $display("FAIL after_abort_data got=%h exp=5a", d); end
    compared++; if ({pe, fe} !== 2'b00) begin failed++; $display("FAIL after_abort_errs got=%b exp=00", {pe, fe}); end
  endtask

  task automatic test_maxflag_timing;
    @(posedge clk); #1;
    waitstate = 1'b0;
    @(posedge clk); #1;
    waitstate = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      compared++; if (maxflag_e !== (k == 18)) begin failed++; $display("FAIL mf_first k=%0d got=%b exp=%b", k, maxflag_e, (k == 18)); end
      @(posedge clk); #1;
    end
    waitstate = 1'b0; datastate = 1'b1;
    @(posedge clk); #1;
    datastate = 1'b0; waitstate = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      compared++; if (maxflag_e !== (k == 14)) begin failed++; $display("FAIL mf_next k=%0d got=%b exp=%b", k, maxflag_e, (k == 14)); end
      @(posedge clk); #1;
    end
    waitstate = 1'b0;
    @(negedge clk);
    compared++; if (maxflag_e !== 1'b0) begin failed++; $display("FAIL mf_nowait got=%b exp=0", maxflag_e); end
    @(posedge clk); #1;
    waitstate = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      compared++; if (maxflag_e !== (k == 14)) begin failed++; $display("FAIL mf_cleared k=%0d got=%b exp=%b", k, maxflag_e, (k == 14)); end
      @(posedge clk); #1;
    end
    waitstate = 1'b0;
  endtask

  task automatic test_saturation;
    @(posedge clk); #1;
    waitstate = 1'b0;
    datastate = 1'b1;
    repeat (16) @(posedge clk);
    #1;
    datastate = 1'b0; waitstate = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      compared++; if (maxflag_e !== (k == 14)) begin failed++; $display("FAIL sat_mf k=%0d got=%b exp=%b", k, maxflag_e, (k == 14)); end
      @(posedge clk); #1;
    end
    waitstate = 1'b0; stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0; waitstate = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      compared++; if (maxflag_e !== (k == 18)) begin failed++; $display("FAIL stop_clears_mf k=%0d got=%b exp=%b", k, maxflag_e, (k == 18)); end
      @(posedge clk); #1;
    end
    waitstate = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_back_to_back;
    bit tmo1, tmo2; logic a0, a1, a2, ape, afe, b0, b1, b2, bpe, bfe; logic [7:0] ad, bd;
    fork
      begin
        drive_frame(8'h00, 1'b1, 1'b1, 10);
        drive_frame(8'hFF, 1'b1, 1'b1, 10);
      end
      begin
        fsm_frame(10, 1'b1, tmo1, a0, a1, a2, ad, ape, afe);
        fsm_frame(10, 1'b1, tmo2, b0, b1, b2, bd, bpe, bfe);
      end
    join
    compared++; if (tmo1 || tmo2) begin failed++; $display("FAIL b2b_timeout got=%b%b exp=00", tmo1, tmo2); end
    compared++; if ({a0, a1, a2} !== 3'b010) begin failed++; $display("FAIL b2b_valid1 got=%b exp=010", {a0, a1, a2}); end
    compared++; if (ad !== 8'h00) begin failed++; $display("FAIL b2b_data1 got=%h exp=00", ad); end
    compared++; if ({ape, afe} !== 2'b00) begin failed++; $display("FAIL b2b_errs1 got=%b exp=00", {ape, afe}); end
    compared++; if ({b0, b1, b2} !== 3'b010) begin failed++; $display("FAIL b2b_valid2 got=%b exp=010", {b0, b1, b2}); end
    compared++; if (bd !== 8'hFF) begin failed++; $display("FAIL b2b_data2 got=%h exp=ff", bd); end
    compared++; if ({bpe, bfe} !== 2'b00) begin failed++; $display("FAIL b2b_errs2 got=%b exp=00", {bpe, bfe}); end
    compared++; if ({rx_data_e, parity_err_e} !== {8'hFF, 1'b1}) begin failed++; $display("FAIL b2b_even_view got=%h/%b exp=ff/1", rx_data_e, parity_err_e); end
  endtask

  initial begin
    test_reset;
    test_good_frame;
    test_parity_error;
    test_frame_error;
    test_reset_mid_frame;
    test_maxflag_timing;
    test_saturation;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
